// File: rtl/param_nibble_alu_seq.sv
// Nibble-serial sequencer around a 4-bit ALU slice: streams one 32-bit operation through
// the slice LSB nibble first, chaining carry, and assembles the result and compare flags.
module param_nibble_alu_seq #(
    parameter int P_NBITS = 4,
    parameter int P_XLEN  = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_op,
    input  logic [P_XLEN-1:0]  req_a,
    input  logic [P_XLEN-1:0]  req_b,
    output logic [P_NBITS-1:0] alu_in_a,
    output logic [P_NBITS-1:0] alu_in_b,
    output logic               alu_in_c,
    output logic               alu_addsub_fn,
    output logic [1:0]         alu_logic_fn,
    input  logic [P_NBITS-1:0] alu_sum_out,
    input  logic               alu_carry_out,
    input  logic               alu_a_b_not_eq,
    input  logic [P_NBITS-1:0] alu_fn_out,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [P_XLEN-1:0]  resp_result,
    output logic               resp_eq,
    output logic               resp_lt,
    output logic               resp_ltu,
    output logic               resp_carry
);

    localparam int C_N_OFF   = P_XLEN / P_NBITS;
    localparam int C_OFFBITS = $clog2(C_N_OFF);
    localparam logic [C_OFFBITS-1:0] C_LAST = C_OFFBITS'(C_N_OFF - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [C_OFFBITS-1:0]  cnt_q, cnt_d;
    logic [P_XLEN-1:0]     a_q, a_d;
    logic [P_XLEN-1:0]     b_q, b_d;
    logic [2:0]            op_q, op_d;
    logic                  carry_q, carry_d;
    logic                  neq_q, neq_d;
    logic [P_XLEN-1:0]     res_q, res_d;
    logic                  eq_q, eq_d;
    logic                  lt_q, lt_d;
    logic                  ltu_q, ltu_d;
    logic                  cout_q, cout_d;

    logic                  is_arith;
    logic                  is_sub;
    logic                  busy;
    logic [P_NBITS-1:0]    nib_sel;
    logic                  a_msb, b_msb, s_msb;
    logic                  neq_all;

    assign is_arith = ~op_q[2];
    assign is_sub   = ~op_q[2] & op_q[0];
    assign busy     = (state_q == S_BUSY);
    assign nib_sel  = op_q[2] ? alu_fn_out : alu_sum_out;
    // On the last nibble the low nibble of the shift regs holds the operand sign bits.
    assign a_msb    = a_q[P_NBITS-1];
    assign b_msb    = b_q[P_NBITS-1];
    assign s_msb    = alu_sum_out[P_NBITS-1];
    assign neq_all  = neq_q | alu_a_b_not_eq;

    assign req_rdy       = (state_q == S_IDLE);
    assign resp_val      = (state_q == S_DONE);
    assign alu_in_a      = busy ? a_q[P_NBITS-1:0] : '0;
    assign alu_in_b      = busy ? b_q[P_NBITS-1:0] : '0;
    assign alu_in_c      = busy ? ((cnt_q == '0) ? is_sub : carry_q) : 1'b0;
    assign alu_addsub_fn = is_sub;
    assign alu_logic_fn  = op_q[1:0];
    assign resp_result   = res_q;
    assign resp_eq       = eq_q;
    assign resp_lt       = lt_q;
    assign resp_ltu      = ltu_q;
    assign resp_carry    = cout_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        neq_d   = neq_q;
        res_d   = res_q;
        eq_d    = eq_q;
        lt_d    = lt_q;
        ltu_d   = ltu_q;
        cout_d  = cout_q;
        case (state_q)
            S_IDLE: begin
                if (req_val) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    op_d    = req_op;
                    cnt_d   = '0;
                    neq_d   = 1'b0;
                    carry_d = 1'b0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                a_d     = a_q >> P_NBITS;
                b_d     = b_q >> P_NBITS;
                res_d   = {nib_sel, res_q[P_XLEN-1:P_NBITS]};
                carry_d = alu_carry_out;
                neq_d   = neq_all;
                cnt_d   = cnt_q + C_OFFBITS'(1);
                if (cnt_q == C_LAST) begin
                    state_d = S_DONE;
                    eq_d    = ~neq_all;
                    cout_d  = is_arith & alu_carry_out;
                    ltu_d   = is_sub & ~alu_carry_out;
                    // Signed less-than: sign of difference, corrected on overflow.
                    lt_d    = is_sub & (s_msb ^ ((a_msb ^ b_msb) & (a_msb ^ s_msb)));
                end
            end
            S_DONE: begin
                if (resp_rdy) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            neq_q   <= 1'b0;
            res_q   <= '0;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            ltu_q   <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            neq_q   <= neq_d;
            res_q   <= res_d;
            eq_q    <= eq_d;
            lt_q    <= lt_d;
            ltu_q   <= ltu_d;
            cout_q  <= cout_d;
        end
    end

endmodule
